// File: rtl/u3v_flag_ctrl_if.sv
// Phase-flag bundle between the U3V frame sequencer and the leader/chunk/trailer generators.
interface u3v_flag_ctrl_if #(
  parameter int LONG_REG_WD = 64
);
  logic                   i_stream_enable;
  logic                   i_fval;
  logic                   i_chunk_mode_active;
  logic                   o_leader_flag;
  logic                   o_payload_flag;
  logic                   o_chunk_flag;
  logic                   o_trailer_flag;
  logic                   o_frame_done;
  logic [LONG_REG_WD-1:0] ov_blockid;
  logic                   o_busy;

  modport master (
    input  i_stream_enable, i_fval, i_chunk_mode_active,
    output o_leader_flag, o_payload_flag, o_chunk_flag, o_trailer_flag,
           o_frame_done, ov_blockid, o_busy
  );

  modport slave (
    output i_stream_enable, i_fval, i_chunk_mode_active,
    input  o_leader_flag, o_payload_flag, o_chunk_flag, o_trailer_flag,
           o_frame_done, ov_blockid, o_busy
  );
endinterface

// File: rtl/u3v_flag_ctrl.sv
// U3V frame sequencer: leader / payload / optional chunk / trailer phase flags and block ID.
// Define U3V_CHUNK_EN to build the chunk phase; without it the chunk flag is constant 0.
module u3v_flag_ctrl #(
  parameter int LONG_REG_WD    = 64,
  parameter int LEADER_CYCLES  = 14,
  parameter int CHUNK_CYCLES   = 8,
  parameter int TRAILER_CYCLES = 10,
  parameter int GAP_CYCLES     = 2
) (
  input logic             clk,
  input logic             reset,
  u3v_flag_ctrl_if.master bus
);

  localparam int MAX_LT  = (LEADER_CYCLES > TRAILER_CYCLES) ? LEADER_CYCLES : TRAILER_CYCLES;
  localparam int MAX_CG  = (CHUNK_CYCLES > GAP_CYCLES) ? CHUNK_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_LT > MAX_CG) ? MAX_LT : MAX_CG;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, LEADER, GAP_L, PAYLOAD, GAP_P,
`ifdef U3V_CHUNK_EN
    CHUNK, GAP_C,
`endif
    TRAILER
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   fval_d;
  logic                   armed;
  logic                   frame_start;
  logic                   trailer_exit;
  logic [LONG_REG_WD-1:0] blockid;

`ifdef U3V_CHUNK_EN
  logic chunk_lat;
`else
  logic unused_chunk_mode;
  assign unused_chunk_mode = bus.i_chunk_mode_active;
  assign bus.o_chunk_flag  = 1'b0;
`endif

  function automatic logic last_cycle(input logic [CNT_W-1:0] c, input int len);
    return c == CNT_W'(len - 1);
  endfunction

  // armed stays low until i_fval has been seen low once, so a frame already
  // in flight when reset releases is never mistaken for a fresh start.
  assign frame_start  = bus.i_fval & ~fval_d & bus.i_stream_enable & armed;
  assign trailer_exit = (state == TRAILER) && (state_nxt == IDLE);
  assign bus.ov_blockid = blockid;

  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_start)                         state_nxt = LEADER;
      LEADER:  if (last_cycle(cnt, LEADER_CYCLES))      state_nxt = GAP_L;
      GAP_L:   if (last_cycle(cnt, GAP_CYCLES))         state_nxt = PAYLOAD;
      PAYLOAD: if (!bus.i_fval)                         state_nxt = GAP_P;
      GAP_P:   if (last_cycle(cnt, GAP_CYCLES)) begin
`ifdef U3V_CHUNK_EN
        state_nxt = chunk_lat ? CHUNK : TRAILER;
`else
        state_nxt = TRAILER;
`endif
      end
`ifdef U3V_CHUNK_EN
      CHUNK:   if (last_cycle(cnt, CHUNK_CYCLES))       state_nxt = GAP_C;
      GAP_C:   if (last_cycle(cnt, GAP_CYCLES))         state_nxt = TRAILER;
`endif
      TRAILER: if (last_cycle(cnt, TRAILER_CYCLES))     state_nxt = IDLE;
      default:                                          state_nxt = IDLE;
    endcase
  end

  // Outputs are registered decodes of state_nxt, so each flag is high exactly
  // while its state is occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      fval_d             <= 1'b0;
      armed              <= 1'b0;
      blockid            <= '0;
      bus.o_leader_flag  <= 1'b0;
      bus.o_payload_flag <= 1'b0;
      bus.o_trailer_flag <= 1'b0;
      bus.o_frame_done   <= 1'b0;
      bus.o_busy         <= 1'b0;
`ifdef U3V_CHUNK_EN
      chunk_lat          <= 1'b0;
      bus.o_chunk_flag   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments only, so every register samples pre-edge values.
      fval_d <= bus.i_fval;
      if (!bus.i_fval) armed <= 1'b1;
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);

      // The TRAILER-exit increment wins over the disable clear.
      if (trailer_exit)              blockid <= blockid + LONG_REG_WD'(1);
      else if (!bus.i_stream_enable) blockid <= '0;

      bus.o_leader_flag  <= (state_nxt == LEADER);
      bus.o_payload_flag <= (state_nxt == PAYLOAD);
      bus.o_trailer_flag <= (state_nxt == TRAILER);
      bus.o_frame_done   <= trailer_exit;
      bus.o_busy         <= (state_nxt != IDLE);
`ifdef U3V_CHUNK_EN
      if (state == IDLE && frame_start) chunk_lat <= bus.i_chunk_mode_active;
      bus.o_chunk_flag <= (state_nxt == CHUNK);
`endif
    end
  end

endmodule
